// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data wins contention, bounded by MAX_DATA_RUN grants so fetch is never starved.
module mem_arbiter #(
    parameter int unsigned MAX_DATA_RUN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [3:0]  dm_be,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;
    localparam int unsigned CW = 4;

    localparam logic [CW-1:0] RUN_LIMIT = CW'(MAX_DATA_RUN);
    localparam logic [CW-1:0] RUN_SAT   = '1;

    typedef enum logic [1:0] {
        IDLE,
        IF_ACC,
        DM_ACC
    } state_e;

    state_e          state_q,     state_d;
    logic [CW-1:0]   run_cnt_q,   run_cnt_d;
    logic            mem_en_q,    mem_en_d;
    logic            mem_we_q,    mem_we_d;
    logic [BW-1:0]   mem_be_q,    mem_be_d;
    logic [AW-1:0]   mem_addr_q,  mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DW-1:0]   if_rdata_q,  if_rdata_d;
    logic [DW-1:0]   dm_rdata_q,  dm_rdata_d;
    logic            if_ready_q,  if_ready_d;
    logic            dm_ready_q,  dm_ready_d;

    logic            if_eff_c;
    logic            dm_eff_c;
    logic            unused_addr_lsbs;

    // A requester is not eligible in its own ready cycle.
    assign if_eff_c = if_req & ~if_ready_q;
    assign dm_eff_c = dm_req & ~dm_ready_q;

    // Memory is word addressed; byte offsets are dropped.
    assign unused_addr_lsbs = ^{if_addr[1:0], dm_addr[1:0]};

    always_comb begin
        state_d     = state_q;
        run_cnt_d   = run_cnt_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (dm_eff_c && (!if_eff_c || (run_cnt_q < RUN_LIMIT))) begin
                    state_d     = DM_ACC;
                    mem_en_d    = 1'b1;
                    mem_we_d    = dm_we;
                    mem_be_d    = dm_we ? dm_be : '1;
                    mem_addr_d  = {dm_addr[AW-1:2], 2'b00};
                    mem_wdata_d = dm_wdata;
                    // Only consecutive data wins over a waiting fetch count.
                    if (if_eff_c) begin
                        run_cnt_d = (run_cnt_q == RUN_SAT) ? RUN_SAT : run_cnt_q + CW'(1);
                    end else begin
                        run_cnt_d = '0;
                    end
                end else if (if_eff_c) begin
                    state_d     = IF_ACC;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = '1;
                    mem_addr_d  = {if_addr[AW-1:2], 2'b00};
                    mem_wdata_d = '0;
                    run_cnt_d   = '0;
                end
            end
            IF_ACC: begin
                if (mem_ack) begin
                    if_rdata_d = mem_rdata;
                    if_ready_d = 1'b1;
                    mem_en_d   = 1'b0;
                    state_d    = IDLE;
                end
            end
            DM_ACC: begin
                if (mem_ack) begin
                    dm_rdata_d = mem_rdata;
                    dm_ready_d = 1'b1;
                    mem_en_d   = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            run_cnt_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_cnt_q   <= run_cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_ready  = if_ready_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_ready  = dm_ready_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory responder model, ready/rdata scoreboard,
// table of single accesses and hand-written contention and reset sequences.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [3:0]  dm_be = '0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    mem_arbiter #(.MAX_DATA_RUN(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } grant_t;

    typedef struct {
        bit          is_dm;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wait_n;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        bit          chk_wdata;
        int          exp_lat;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    int          mem_wait = 0;
    int          last_en_cycles = 0;
    bit          model_on = 1'b1;
    logic        force_ack = 1'b0;
    grant_t      glog[$];
    logic [31:0] exp_if_q[$];
    logic [31:0] exp_dm_q[$];

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0000_3004) return 32'h2008_0005;
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Memory responder: logs each new command, acks after mem_wait extra cycles
    // and queues the returned word as the expected read data for that port.
    task automatic model_proc();
        int wcnt = 0;
        forever begin
            @(negedge clk);
            if (!model_on) begin
                mem_ack = force_ack;
            end else if (mem_en) begin
                if (wcnt == 0) glog.push_back('{mem_we, mem_be, mem_addr, mem_wdata});
                if (wcnt == mem_wait) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_fn(mem_addr);
                    last_en_cycles = wcnt + 1;
                    if (mem_addr >= 32'h0000_3000) exp_if_q.push_back(mem_rdata);
                    else exp_dm_q.push_back(mem_rdata);
                    wcnt = 0;
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ack = 1'b0;
                wcnt = 0;
            end
        end
    endtask

    task automatic monitor_proc();
        forever begin
            @(negedge clk);
            if (if_ready) begin
                if (exp_if_q.size() == 0) chk("if_ready_unexpected", 32'(if_ready), 32'd0);
                else chk("if_rdata", if_rdata, exp_if_q.pop_front());
            end
            if (dm_ready) begin
                if (exp_dm_q.size() == 0) chk("dm_ready_unexpected", 32'(dm_ready), 32'd0);
                else chk("dm_rdata", dm_rdata, exp_dm_q.pop_front());
            end
        end
    endtask

    task automatic wait_ready(input bit is_dm, output int lat);
        lat = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            lat++;
            if (is_dm ? dm_ready : if_ready) return;
        end
        chk(is_dm ? "dm_ready_timeout" : "if_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int c = 0; c < 6; c++) step();
    endtask

    task automatic check_order(input string name, input string exp_s);
        chk({name, "_count"}, 32'(glog.size()), 32'(exp_s.len()));
        for (int i = 0; i < exp_s.len() && i < glog.size(); i++) begin
            byte act_c;
            act_c = (glog[i].addr >= 32'h0000_3000) ? "I" : "D";
            chk(name, 32'(act_c), 32'(exp_s[i]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   lat;

        vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_3004, 32'h0,          0, 32'h0000_3004, 1'b0, 4'hF, 32'h0,          1'b1, 2};
        vecs[1] = '{1'b1, 1'b1, 4'h3, 32'h0000_0052, 32'h1234_ABCD, 3, 32'h0000_0050, 1'b1, 4'h3, 32'h1234_ABCD, 1'b1, 5};
        vecs[2] = '{1'b1, 1'b0, 4'h1, 32'h0000_0107, 32'hFFFF_0000, 1, 32'h0000_0104, 1'b0, 4'hF, 32'h0,          1'b0, 3};
        vecs[3] = '{1'b0, 1'b0, 4'h0, 32'h0000_3FFF, 32'h0,          2, 32'h0000_3FFC, 1'b0, 4'hF, 32'h0,          1'b1, 4};
        vecs[4] = '{1'b1, 1'b1, 4'hF, 32'h0000_0FFC, 32'hCAFE_F00D, 0, 32'h0000_0FFC, 1'b1, 4'hF, 32'hCAFE_F00D, 1'b1, 2};

        fork
            model_proc();
            monitor_proc();
        join_none

        // Reset held with both requesters active.
        if_addr = 32'h0000_3008;
        dm_addr = 32'h0000_0010;
        if_req = 1'b1;
        dm_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rst_mem_en", 32'(mem_en), 32'd0);
        end
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        chk("rst_readys", {30'd0, if_ready, dm_ready}, 32'd0);
        chk("rst_mem_cmd", {27'd0, mem_we, mem_be}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b1;
        step();
        chk("rst_release_mem_en", 32'(mem_en), 32'd1);
        chk("rst_release_dm_wins", mem_addr, 32'h0000_0010);
        wait_ready(1'b1, lat);
        dm_req = 1'b0;
        wait_ready(1'b0, lat);
        if_req = 1'b0;
        drain();
        check_order("rst_order", "DI");

        // Single accesses from the table.
        for (int v = 0; v < 5; v++) begin
            glog.delete();
            mem_wait = vecs[v].wait_n;
            if (vecs[v].is_dm) begin
                dm_we = vecs[v].we;
                dm_be = vecs[v].be;
                dm_addr = vecs[v].addr;
                dm_wdata = vecs[v].wdata;
                dm_req = 1'b1;
            end else begin
                if_addr = vecs[v].addr;
                dm_wdata = 32'hDEAD_BEEF;
                if_req = 1'b1;
            end
            wait_ready(vecs[v].is_dm, lat);
            if_req = 1'b0;
            dm_req = 1'b0;
            chk($sformatf("vec%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
            chk($sformatf("vec%0d_en_cycles", v), 32'(last_en_cycles), 32'(vecs[v].wait_n + 1));
            chk($sformatf("vec%0d_grants", v), 32'(glog.size()), 32'd1);
            if (glog.size() > 0) begin
                chk($sformatf("vec%0d_addr", v), glog[0].addr, vecs[v].exp_addr);
                chk($sformatf("vec%0d_we", v), 32'(glog[0].we), 32'(vecs[v].exp_we));
                chk($sformatf("vec%0d_be", v), 32'(glog[0].be), 32'(vecs[v].exp_be));
                if (vecs[v].chk_wdata)
                    chk($sformatf("vec%0d_wdata", v), glog[0].wdata, vecs[v].exp_wdata);
            end
            drain();
        end
        mem_wait = 0;
        dm_we = 1'b0;

        // Ready masking: fetch held high through its ready cycle.
        glog.delete();
        if_addr = 32'h0000_3020;
        if_req = 1'b1;
        wait_ready(1'b0, lat);
        chk("mask_ready_cycle_en", 32'(mem_en), 32'd0);
        step();
        chk("mask_next_cycle_en", 32'(mem_en), 32'd0);
        step();
        chk("mask_regrant_en", 32'(mem_en), 32'd1);
        if_req = 1'b0;
        drain();
        chk("mask_grants", 32'(glog.size()), 32'd2);

        // Both held: each ready cycle hands the slot to the other requester.
        glog.delete();
        dm_addr = 32'h0000_0040;
        if_addr = 32'h0000_3010;
        dm_req = 1'b1;
        if_req = 1'b1;
        for (int c = 0; c < 200 && glog.size() < 6; c++) step();
        dm_req = 1'b0;
        if_req = 1'b0;
        drain();
        check_order("alt_order", "DIDIDI");

        // Fetch withdraws during data ready cycles, so data keeps winning until the
        // run limit forces fetch; the data grant in the fetch ready cycle sees no
        // pending fetch and restarts the run from zero.
        glog.delete();
        dm_req = 1'b1;
        if_req = 1'b1;
        for (int c = 0; c < 300 && glog.size() < 11; c++) begin
            step();
            if_req = dm_ready ? 1'b0 : 1'b1;
        end
        dm_req = 1'b0;
        if_req = 1'b0;
        drain();
        check_order("run_order", "DDDDIDDDDDI");

        // Reset in the middle of a data access, then a late ack.
        glog.delete();
        model_on = 1'b0;
        force_ack = 1'b0;
        dm_addr = 32'h0000_0020;
        dm_req = 1'b1;
        for (int c = 0; c < 20 && !mem_en; c++) step();
        chk("midrst_granted", 32'(mem_en), 32'd1);
        step();
        @(posedge clk);
        #2;
        rst = 1'b0;
        dm_req = 1'b0;
        #1;
        chk("midrst_async_en", 32'(mem_en), 32'd0);
        step();
        rst = 1'b1;
        force_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("midrst_no_ready", {30'd0, if_ready, dm_ready}, 32'd0);
            chk("midrst_en_low", 32'(mem_en), 32'd0);
        end
        force_ack = 1'b0;
        step();
        chk("midrst_dm_rdata", dm_rdata, 32'd0);
        model_on = 1'b1;
        step();
        if_addr = 32'h0000_3030;
        if_req = 1'b1;
        wait_ready(1'b0, lat);
        if_req = 1'b0;
        chk("midrst_idle_latency", 32'(lat), 32'd2);
        drain();

        chk("sb_if_drained", 32'(exp_if_q.size()), 32'd0);
        chk("sb_dm_drained", 32'(exp_dm_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
